// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller, datapath and ALU control decoder:
// FSM state codes, opcodes, mux-select encodings and the control-word struct.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_ADDI_EXE = 4'd8,
    S_ADDI_WB  = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REGB    = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SHL = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_t;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_source_t pc_source;
    logic       error;
  } ctrl_t;

  // States that talk to memory and therefore wait on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive mem_ready-low cycles in a memory state and flags a timeout
// on the cycle the count would reach WAIT_MAX with memory still not ready.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int            CW   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] r_count;

  // Outside a memory state, or once an access completes, the count is parked at
  // zero, so every entry into FETCH/MEM_RD/MEM_WR starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_active || i_ready || o_timeout) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_timeout = i_active && !i_ready && (r_count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: decodes the registered state into datapath
// strobes and selects, with a memory-wait watchdog that traps into HALT.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       error
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  logic   w_mem_active;
  logic   w_timeout;

  assign w_mem_active = is_mem_state(r_state);

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_mem_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_active  (w_mem_active),
    .i_ready   (mem_ready),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; no latches inferred.
    w_next = r_state;
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.ir_write  = mem_ready;
        w_ctrl.pc_en     = mem_ready;
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_HALT;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = SRCB_IMM_SHL;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_R:         w_next = S_R_EXE;
          OP_ADDI:      w_next = S_ADDI_EXE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        if (opcode == OP_LW)      w_next = S_MEM_RD;
        else if (opcode == OP_SW) w_next = S_MEM_WR;
        else                      w_next = S_HALT;
      end
      S_MEM_RD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
        if (mem_ready)      w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_HALT;
      end
      S_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_next            = S_FETCH;
      end
      S_MEM_WR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_HALT;
      end
      S_R_EXE: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REGB;
        w_ctrl.alu_op    = ALU_FUNCT;
        w_next           = S_R_WB;
      end
      S_R_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_next           = S_FETCH;
      end
      S_ADDI_EXE: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_next           = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_next           = S_FETCH;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REGB;
        w_ctrl.alu_op    = ALU_SUB;
        w_ctrl.pc_source = PCSRC_ALUOUT;
        w_ctrl.pc_en     = zero;
        w_next           = S_FETCH;
      end
      S_JUMP: begin
        w_ctrl.pc_source = PCSRC_JUMP;
        w_ctrl.pc_en     = 1'b1;
        w_next           = S_FETCH;
      end
      S_HALT: begin
        w_ctrl.error = 1'b1;
      end
      default: begin
        w_next = S_HALT;
      end
    endcase
  end

  // Reset parks the FSM in FETCH, whose pc_en/ir_write follow mem_ready; gating
  // them with rst_n keeps the PC and IR untouched while reset is held.
  assign pc_en      = w_ctrl.pc_en & rst_n;
  assign ir_write   = w_ctrl.ir_write & rst_n;
  assign iord       = w_ctrl.iord;
  assign mem_read   = w_ctrl.mem_read;
  assign mem_write  = w_ctrl.mem_write;
  assign reg_write  = w_ctrl.reg_write;
  assign reg_dst    = w_ctrl.reg_dst;
  assign mem_to_reg = w_ctrl.mem_to_reg;
  assign alu_src_a  = w_ctrl.alu_src_a;
  assign alu_src_b  = w_ctrl.alu_src_b;
  assign alu_op     = w_ctrl.alu_op;
  assign pc_source  = w_ctrl.pc_source;
  assign error      = w_ctrl.error;
  assign state      = r_state;

endmodule
